// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic [1:0] {
        P2S_IDLE  = 2'd0,
        P2S_LOAD  = 2'd1,
        P2S_SHIFT = 2'd2,
        P2S_GAP   = 2'd3
    } p2s_state_e;

    // Smallest counter width that can hold max(DW, GAP) - 1.
    function automatic int unsigned p2s_min_aw(input int unsigned dw, input int unsigned gap);
        int unsigned span;
        span = (dw > gap) ? dw : gap;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/p2s_if.sv
// Parallel-side valid/ready handshake of the serial transmitter.
interface p2s_if #(
    parameter int DW = 22
);
    logic [DW-1:0] par_din;
    logic          par_valid;
    logic          par_ready;

    modport master (output par_din, output par_valid, input par_ready);
    modport slave  (input par_din, input par_valid, output par_ready);
endinterface

// File: rtl/p2s_hold_buf.sv
// One-entry holding register; ready is the registered empty flag, no path from valid.
module p2s_hold_buf #(
    parameter int DW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          valid,
    output logic          ready,
    input  logic          consume,
    output logic [DW-1:0] data,
    output logic          vld
);

    // Accept and consume can never coincide: consume needs vld, accept needs !vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (valid && !vld) begin
            vld  <= 1'b1;
            data <= din;
        end else if (consume) begin
            vld <= 1'b0;
        end
    end

    assign ready = ~vld;

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: start strobe, DW data bits, then GAP idle cycles.
module p2s_tx
    import p2s_pkg::*;
#(
    parameter int DW        = 22,
    parameter int AW        = 5,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst_n,
    p2s_if.slave par,
    output logic ser_start,
    output logic ser_dout,
    output logic ser_busy,
    output logic tx_done
);

    localparam int unsigned DW_LAST  = DW - 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    p2s_state_e    state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] shr;
    logic [DW-1:0] shr_next;
    logic [DW-1:0] hold;
    logic          hold_vld;
    logic          last_bit;
    logic          gap_end;
    logic          load;
    logic          bit_first;
    logic          bit_next;

    p2s_hold_buf #(.DW(DW)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (par.par_din),
        .valid   (par.par_valid),
        .ready   (par.par_ready),
        .consume (load),
        .data    (hold),
        .vld     (hold_vld)
    );

    if (MSB_FIRST != 0) begin : g_msb
        assign shr_next  = {shr[DW-2:0], 1'b0};
        assign bit_first = shr[DW-1];
        assign bit_next  = shr[DW-2];
    end else begin : g_lsb
        assign shr_next  = {1'b0, shr[DW-1:1]};
        assign bit_first = shr[0];
        assign bit_next  = shr[1];
    end

    assign last_bit = (state == P2S_SHIFT) && (cnt == AW'(DW_LAST));
    assign gap_end  = (state == P2S_GAP) && (cnt == AW'(GAP_LAST));
    assign load     = hold_vld && ((state == P2S_IDLE) || gap_end || (last_bit && (GAP == 0)));

    // Outputs are registered one edge ahead, so ser_dout is loaded with the bit the next state shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= P2S_IDLE;
            cnt       <= '0;
            shr       <= '0;
            ser_start <= 1'b0;
            ser_dout  <= 1'b0;
            ser_busy  <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            ser_start <= load;
            ser_dout  <= 1'b0;
            tx_done   <= last_bit;
            if (load) begin
                state    <= P2S_LOAD;
                shr      <= hold;
                cnt      <= '0;
                ser_busy <= 1'b1;
            end else begin
                case (state)
                    P2S_IDLE: ser_busy <= 1'b0;
                    P2S_LOAD: begin
                        state    <= P2S_SHIFT;
                        ser_dout <= bit_first;
                    end
                    P2S_SHIFT: begin
                        shr <= shr_next;
                        if (last_bit) begin
                            cnt <= '0;
                            if (GAP > 0) begin
                                state <= P2S_GAP;
                            end else begin
                                state    <= P2S_IDLE;
                                ser_busy <= 1'b0;
                            end
                        end else begin
                            cnt      <= cnt + AW'(1);
                            ser_dout <= bit_next;
                        end
                    end
                    P2S_GAP: begin
                        if (gap_end) begin
                            state    <= P2S_IDLE;
                            ser_busy <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                    default: state <= P2S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: three configurations against a frame-timeline reference model.
module tb_p2s_tx;

    localparam int DW   = 22;
    localparam int AW   = 5;
    localparam int NI   = 3;
    localparam int MAXF = 128;
    localparam int GAPS [NI] = '{2, 0, 2};
    localparam int MSBS [NI] = '{1, 1, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [DW-1:0] p_din [NI];
    logic [NI-1:0] p_valid;
    logic [NI-1:0] p_ready;
    logic [NI-1:0] s_start;
    logic [NI-1:0] s_dout;
    logic [NI-1:0] s_busy;
    logic [NI-1:0] s_done;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model: every accepted word becomes a frame with a start cycle.
    int            fs [NI][MAXF];
    logic [DW-1:0] fw [NI][MAXF];
    int            nf [NI];
    int            last_start [NI];
    int            held_until [NI];
    bit            acc_now [NI];
    int            acc_cyc [NI];

    int obs_s [NI][MAXF];
    int nobs  [NI];
    int ndone [NI];
    int ncoin [NI];

    logic [DW-1:0] sw [4] = '{22'h000001, 22'h200000, 22'h155555, 22'h2AAAAA};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        p2s_if #(.DW(DW)) pif ();
        assign pif.par_din   = p_din[g];
        assign pif.par_valid = p_valid[g];
        assign p_ready[g]    = pif.par_ready;

        p2s_tx #(.DW(DW), .AW(AW), .GAP(GAPS[g]), .MSB_FIRST(MSBS[g])) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .par       (pif),
            .ser_start (s_start[g]),
            .ser_dout  (s_dout[g]),
            .ser_busy  (s_busy[g]),
            .tx_done   (s_done[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    function automatic int period(input int i);
        return DW + 1 + GAPS[i];
    endfunction

    // Outputs in cycle t derived from frame start times: strobe, data bits, done, busy window.
    function automatic logic [4:0] model_out(input int i, input int t);
        logic st = 1'b0;
        logic d  = 1'b0;
        logic b  = 1'b0;
        logic dn = 1'b0;
        logic r;
        for (int f = 0; f < nf[i]; f++) begin
            int s;
            int k;
            s = fs[i][f];
            k = t - s - 1;
            if (t == s) st = 1'b1;
            if (k >= 0 && k < DW) d = (MSBS[i] != 0) ? fw[i][f][DW-1-k] : fw[i][f][k];
            if (k == DW) dn = 1'b1;
            if (t >= s && t < s + period(i)) b = 1'b1;
        end
        r = !(t < held_until[i]);
        return {st, d, b, dn, r};
    endfunction

    always @(posedge clk) begin
        int s;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            acc_now[i] = 1'b0;
            if (!rst_n) begin
                nf[i]         = 0;
                last_start[i] = -1000;
                held_until[i] = -1;
            end else if (p_valid[i] && !(cyc - 1 < held_until[i]) && nf[i] < MAXF) begin
                s = (cyc + 1 > last_start[i] + period(i)) ? cyc + 1 : last_start[i] + period(i);
                fs[i][nf[i]]  = s;
                fw[i][nf[i]]  = p_din[i];
                nf[i]         = nf[i] + 1;
                last_start[i] = s;
                held_until[i] = s;
                acc_now[i]    = 1'b1;
                acc_cyc[i]    = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (s_start[i] && nobs[i] < MAXF) begin
                    obs_s[i][nobs[i]] = cyc;
                    nobs[i] = nobs[i] + 1;
                end
                if (s_done[i]) ndone[i] = ndone[i] + 1;
                if (s_start[i] && s_done[i]) ncoin[i] = ncoin[i] + 1;
                if (chk_en)
                    chk($sformatf("out%0d{start,dout,busy,done,ready}", i),
                        32'({s_start[i], s_dout[i], s_busy[i], s_done[i], p_ready[i]}),
                        32'(model_out(i, cyc)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int i, input logic [DW-1:0] w, output int e0);
        p_din[i]   = w;
        p_valid[i] = 1'b1;
        e0 = -1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (acc_now[i]) begin
                e0 = acc_cyc[i];
                break;
            end
        end
        chk($sformatf("accept%0d_in_time", i), 32'(e0 >= 0), 32'd1);
        p_valid[i] = 1'b0;
    endtask

    task automatic rand_run(input int i);
        int e;
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 30)) tick();
            send(i, DW'($urandom), e);
        end
    endtask

    task automatic all_reset_outputs(input string name);
        for (int i = 0; i < NI; i++)
            chk($sformatf("%s%0d", name, i),
                32'({s_start[i], s_dout[i], s_busy[i], s_done[i], p_ready[i]}), 32'b00001);
    endtask

    initial begin
        int e0, e1, e2, n0, d0, c0;
        int base [NI];
        logic [DW-1:0] bits;
        for (int i = 0; i < NI; i++) p_din[i] = '0;
        p_valid = '0;

        #2 rst_n = 1'b0;
        #1 all_reset_outputs("reset_init");
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();

        // Single word, MSB first, GAP=2.
        n0 = nobs[0];
        send(0, 22'h3C0A51, e0);
        bits = '0;
        while (cyc < e0 + 26) begin
            @(negedge clk);
            case (cyc - e0)
                1:  chk("single_start", 32'(s_start[0]), 32'd1);
                24: chk("single_done", 32'(s_done[0]), 32'd1);
                25: chk("single_busy_gap", 32'(s_busy[0]), 32'd1);
                26: chk("single_busy_end", 32'(s_busy[0]), 32'd0);
                default: ;
            endcase
            if (cyc - e0 >= 2 && cyc - e0 <= 23) bits = {bits[DW-2:0], s_dout[0]};
        end
        chk("single_bits", 32'(bits), 32'(22'b1111000000101001010001));
        chk("single_start_count", 32'(nobs[0] - n0), 32'd1);
        repeat (3) tick();

        // Streaming with valid held.
        n0 = nobs[0];
        d0 = ndone[0];
        for (int j = 0; j < 4; j++) send(0, sw[j], e0);
        repeat (60) tick();
        chk("stream_starts", 32'(nobs[0] - n0), 32'd4);
        chk("stream_dones", 32'(ndone[0] - d0), 32'd4);
        for (int j = 0; j < 3; j++)
            chk("stream_period", 32'(obs_s[0][n0+j+1] - obs_s[0][n0+j]), 32'd25);

        // GAP=0 back-to-back.
        n0 = nobs[1];
        c0 = ncoin[1];
        for (int j = 0; j < 3; j++) send(1, sw[j+1], e0);
        repeat (60) tick();
        chk("gap0_starts", 32'(nobs[1] - n0), 32'd3);
        for (int j = 0; j < 2; j++)
            chk("gap0_period", 32'(obs_s[1][n0+j+1] - obs_s[1][n0+j]), 32'd23);
        chk("gap0_done_with_start", 32'(ncoin[1] - c0), 32'd2);

        // Backpressure: changing din while a word is held.
        send(0, 22'h0F0F0F, e0);
        send(0, 22'h2BCDEF, e1);
        chk("bp_second_accept", 32'(e1 - e0), 32'd2);
        p_valid[0] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            p_din[0] = DW'($urandom);
            tick();
            chk("bp_ready_low", 32'(p_ready[0]), 32'd0);
        end
        send(0, 22'h123456, e2);
        chk("bp_next_accept", 32'(e2 - e0), 32'd27);
        repeat (60) tick();

        // LSB first.
        send(2, 22'h000003, e0);
        bits = '0;
        while (cyc < e0 + 23) begin
            @(negedge clk);
            if (cyc - e0 >= 2) bits = {bits[DW-2:0], s_dout[2]};
        end
        chk("lsb_bits", 32'(bits), 32'(22'h300000));
        repeat (5) tick();

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        repeat (80) tick();

        // Reset mid-SHIFT with a held word.
        send(0, 22'h3FFFFF, e0);
        send(0, 22'h2AAAAA, e1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1 all_reset_outputs("reset_mid");
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) base[i] = nobs[i];
        repeat (40) tick();
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_no_start%0d", i), 32'(nobs[i] - base[i]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
